// File: rtl/spi_lcd_rx_module_if.sv
// -----------------------------------------------------------------------------
// spi_lcd_rx_module_if
// Bundles the observed LCD bus, the FIFO read handshake and the receiver
// status outputs of spi_lcd_rx_module.
//   SPI_In    [3] CS (active-low), [2] A0, [1] SCLK, [0] DO
//   Rd_En     pop FIFO head
//   Rx_Data   FIFO head {A0, byte}
//   Rx_Valid  FIFO not empty
//   Byte_Cnt  complete bytes in current CS frame (saturating)
//   Overflow  sticky, a completed byte was dropped on a full FIFO
//   Frame_Err one-cycle pulse, CS deasserted mid-byte
// master: bench / consumer side.  slave: receiver side.
// -----------------------------------------------------------------------------
interface spi_lcd_rx_module_if;
  logic [3:0] SPI_In;
  logic       Rd_En;
  logic [8:0] Rx_Data;
  logic       Rx_Valid;
  logic [7:0] Byte_Cnt;
  logic       Overflow;
  logic       Frame_Err;

  modport master (
    output SPI_In, Rd_En,
    input  Rx_Data, Rx_Valid, Byte_Cnt, Overflow, Frame_Err
  );

  modport slave (
    input  SPI_In, Rd_En,
    output Rx_Data, Rx_Valid, Byte_Cnt, Overflow, Frame_Err
  );
endinterface

// File: rtl/spi_lcd_rx_module.sv
// -----------------------------------------------------------------------------
// spi_lcd_rx_module
// Oversampling receiver for the 4-wire LCD serial bus. Recovers 8-bit words
// MSB-first with their A0 flag and queues {A0, byte} in a show-ahead FIFO.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous reset, active-high
//   bus  spi_lcd_rx_module_if.slave (bus input, FIFO pop, data and status)
// -----------------------------------------------------------------------------
module spi_lcd_rx_module #(
  parameter int FIFO_AW = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  spi_lcd_rx_module_if.slave    bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  // Synchronizer chain; s3 keeps only the lines whose edges matter.
  logic [3:0] s1, s2;
  logic [1:0] s3;          // {CS, SCLK} previous sample
  logic [1:0] warm_cnt;    // counts edges since reset until s3 holds a real sample

  logic cs_fall, sclk_rise;

  state_t st_q, st_d;
  logic   capture, frame_end;

  logic [6:0] shift_q;
  logic [2:0] bit_cnt;
  logic       wr_req, err_pend;
  logic [8:0] wr_word;

  logic [8:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, do_write;
  logic [7:0]       byte_cnt;
  logic             overflow, frame_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1       <= 4'b1010;
      s2       <= 4'b1010;
      s3       <= 2'b11;
      warm_cnt <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, giving a true shift chain.
      s1 <= bus.SPI_In;
      s2 <= s1;
      s3 <= {s2[3], s2[1]};
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  // A CS fall is trusted only once s3 holds a bus sample rather than its reset
  // value; otherwise a reset during a low CS would fake a frame start.
  assign cs_fall   = ~s2[3] & s3[1] & (warm_cnt == 2'd3);
  assign sclk_rise =  s2[1] & ~s3[0];

  always_ff @(posedge CLK) begin
    if (RST) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    st_d      = st_q;
    capture   = 1'b0;
    frame_end = 1'b0;
    case (st_q)
      ST_IDLE:  if (cs_fall) st_d = ST_FRAME;
      ST_FRAME: begin
        if (s2[3]) begin
          // CS high wins over any SCLK rise seen in the same cycle.
          st_d      = ST_IDLE;
          frame_end = 1'b1;
        end else begin
          capture = sclk_rise;
        end
      end
      default:  st_d = ST_IDLE;
    endcase
  end

  // Capture stage: shift register, bit counter and the one-cycle write request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      wr_req   <= 1'b0;
      wr_word  <= '0;
      err_pend <= 1'b0;
    end else begin
      wr_req   <= 1'b0;
      err_pend <= frame_end & (bit_cnt != 3'd0);
      if (capture) begin
        shift_q <= {shift_q[5:0], s2[0]};
        bit_cnt <= bit_cnt + 3'd1;       // wraps to 0 after the 8th bit
        if (bit_cnt == 3'd7) begin
          wr_req  <= 1'b1;
          wr_word <= {s2[2], shift_q, s2[0]};
        end
      end else if (st_d == ST_IDLE) begin
        // Outside a frame (or ending one) any partial word is discarded.
        shift_q <= '0;
        bit_cnt <= '0;
      end
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop      = bus.Rd_En & ~empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_write = wr_req & (~full | pop);

  // NOTE: FIFO storage has no reset; the pointers alone define which entries
  // are valid, and Rx_Data is forced to zero while empty.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      byte_cnt  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_pend;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (wr_req && full && !pop) overflow <= 1'b1;
      if (cs_fall)
        byte_cnt <= '0;
      else if (wr_req && byte_cnt != 8'hFF)
        byte_cnt <= byte_cnt + 8'd1;
    end
  end

  assign bus.Rx_Valid  = ~empty;
  assign bus.Rx_Data   = empty ? 9'h000 : mem[rd_ptr[FIFO_AW-1:0]];
  assign bus.Byte_Cnt  = byte_cnt;
  assign bus.Overflow  = overflow;
  assign bus.Frame_Err = frame_err;

endmodule

// File: tb/tb_spi_lcd_rx_module.sv
// -----------------------------------------------------------------------------
// tb_spi_lcd_rx_module
// Directed bench for spi_lcd_rx_module: reset idle, single byte with latency,
// mixed A0 frame, truncated frame, overflow with and without a coincident pop,
// and reset in the middle of a byte.
// -----------------------------------------------------------------------------
module tb_spi_lcd_rx_module;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1, a0 = 1'b0, sclk = 1'b1, dout = 1'b0;
  logic rd_en = 1'b0;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int ferr_ref;

  spi_lcd_rx_module_if bus ();

  assign bus.SPI_In = {cs, a0, sclk, dout};
  assign bus.Rd_En  = rd_en;

  spi_lcd_rx_module #(.FIFO_AW(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Number of sampled cycles with Frame_Err high.
  always @(negedge clk) if (bus.Frame_Err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  // Low phase with data set up, then the SCLK rise is driven (not yet waited on).
  task automatic bit_low(input logic a, input logic b);
    sclk = 1'b0; a0 = a; dout = b;
    tick(4);
    sclk = 1'b1;
  endtask

  // Sends the n low bits of d, MSB first, SCLK period 8 CLK.
  task automatic send_bits(input logic a, input logic [7:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_low(a, d[i]);
      tick(4);
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    tick(8);
  endtask

  task automatic pop_check(input string tag, input logic [8:0] exp);
    check({tag, "_valid"}, bus.Rx_Valid, 1'b1);
    check({tag, "_data"}, bus.Rx_Data, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset idle
    tick(3);
    check("rst_data", bus.Rx_Data, 9'h000);
    check("rst_valid", bus.Rx_Valid, 1'b0);
    check("rst_cnt", bus.Byte_Cnt, 8'd0);
    check("rst_ovf", bus.Overflow, 1'b0);
    check("rst_ferr", bus.Frame_Err, 1'b0);
    rst = 1'b0;
    tick(20);
    check("idle_valid", bus.Rx_Valid, 1'b0);
    check("idle_ferr", ferr_cnt, 0);

    // Single command byte 8'hAF with latency check on the 8th rise
    cs_low();
    send_bits(1'b0, 8'h57, 7);            // first seven bits of 8'hAF
    bit_low(1'b0, 1'b1);                  // 8th rise driven now
    tick(3);
    check("lat_not_yet", bus.Rx_Valid, 1'b0);
    tick(1);
    check("lat_valid", bus.Rx_Valid, 1'b1);
    check("af_data", bus.Rx_Data, 9'h0AF);
    check("af_cnt", bus.Byte_Cnt, 8'd1);
    tick(3);
    cs_high();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("af_pop_valid", bus.Rx_Valid, 1'b0);
    check("af_pop_data", bus.Rx_Data, 9'h000);

    // Rd_En while empty does nothing
    rd_en = 1'b1;
    tick(2);
    rd_en = 1'b0;
    check("empty_rd_valid", bus.Rx_Valid, 1'b0);

    // Mixed frame: command then three data bytes
    ferr_ref = ferr_cnt;
    cs_low();
    send_bits(1'b0, 8'h40, 8);
    send_bits(1'b1, 8'h00, 8);
    send_bits(1'b1, 8'hFF, 8);
    send_bits(1'b1, 8'h5A, 8);
    cs_high();
    check("mix_cnt", bus.Byte_Cnt, 8'd4);
    check("mix_ovf", bus.Overflow, 1'b0);
    pop_check("mix0", 9'h040);
    pop_check("mix1", 9'h100);
    pop_check("mix2", 9'h1FF);
    pop_check("mix3", 9'h15A);
    check("mix_empty", bus.Rx_Valid, 1'b0);
    check("mix_ferr", ferr_cnt - ferr_ref, 0);

    // Truncated frame: 5 bits then CS high
    ferr_ref = ferr_cnt;
    cs_low();
    send_bits(1'b0, 8'h16, 5);            // 10110
    cs_high();
    tick(4);
    check("trunc_ferr_pulse", ferr_cnt - ferr_ref, 1);
    check("trunc_valid", bus.Rx_Valid, 1'b0);
    check("trunc_cnt", bus.Byte_Cnt, 8'd0);
    cs_low();
    send_bits(1'b0, 8'h3C, 8);
    cs_high();
    check("after_trunc_cnt", bus.Byte_Cnt, 8'd1);
    pop_check("after_trunc", 9'h03C);
    check("after_trunc_empty", bus.Rx_Valid, 1'b0);
    check("after_trunc_ferr", ferr_cnt - ferr_ref, 1);

    // Overflow: five bytes, no reads
    cs_low();
    for (int b = 1; b <= 5; b++) send_bits(1'b0, 8'(b), 8);
    cs_high();
    check("ovf_flag", bus.Overflow, 1'b1);
    check("ovf_cnt", bus.Byte_Cnt, 8'd5);
    pop_check("ovf0", 9'h001);
    pop_check("ovf1", 9'h002);
    pop_check("ovf2", 9'h003);
    pop_check("ovf3", 9'h004);
    check("ovf_dropped", bus.Rx_Valid, 1'b0);
    check("ovf_sticky", bus.Overflow, 1'b1);

    // Reset clears Overflow; then fifth write coincides with a pop
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("ovf_rst", bus.Overflow, 1'b0);
    tick(4);
    cs_low();
    for (int b = 1; b <= 4; b++) send_bits(1'b0, 8'(b), 8);
    send_bits(1'b0, 8'h02, 7);            // first seven bits of 8'h05
    bit_low(1'b0, 1'b1);
    tick(3);
    rd_en = 1'b1;                         // pop lands on the write cycle
    tick(1);
    rd_en = 1'b0;
    tick(3);
    cs_high();
    check("pop_wr_ovf", bus.Overflow, 1'b0);
    check("pop_wr_cnt", bus.Byte_Cnt, 8'd5);
    pop_check("pw0", 9'h002);
    pop_check("pw1", 9'h003);
    pop_check("pw2", 9'h004);
    pop_check("pw3", 9'h005);
    check("pw_empty", bus.Rx_Valid, 1'b0);

    // Reset in the middle of a byte, CS still low
    ferr_ref = ferr_cnt;
    cs_low();
    send_bits(1'b1, 8'h0A, 4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("midrst_cnt", bus.Byte_Cnt, 8'd0);
    check("midrst_valid", bus.Rx_Valid, 1'b0);
    send_bits(1'b1, 8'hFF, 8);            // no CS fall seen since reset
    tick(4);
    check("midrst_ignored", bus.Rx_Valid, 1'b0);
    cs_high();
    check("midrst_noferr", ferr_cnt - ferr_ref, 0);
    cs_low();
    send_bits(1'b0, 8'hC3, 8);
    cs_high();
    check("c3_cnt", bus.Byte_Cnt, 8'd1);
    pop_check("c3", 9'h0C3);
    check("c3_empty", bus.Rx_Valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_lcd_rx_module.md
# spi_lcd_rx_module

Receive-side decoder for the 4-wire LCD serial bus (CS, A0, SCLK, DO) driven by the LCD write path. It oversamples the bus with the system clock, recovers 8-bit words MSB-first together with their A0 (command/data) flag, and buffers them in a small show-ahead FIFO. The block sits on the bench and debug side of the SPI LCD 12864 design. It lets the init and draw sequences be checked byte-by-byte, and it serves as the front end of an LCD emulator.

## Interface
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (4)
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  synchronous reset, active-high
- SPI_In  input  4  bus under observation, same packing as the write path: [3] CS (active-low), [2] A0, [1] SCLK, [0] DO; asynchronous to CLK
- Rd_En  input  1  pop FIFO head; honoured only while Rx_Valid=1
- Rx_Data  output  9  FIFO head, {A0, byte[7:0]}; valid when Rx_Valid=1
- Rx_Valid  output  1  FIFO not empty
- Byte_Cnt  output  8  complete bytes received in current CS frame, saturates at 255
- Overflow  output  1  sticky; set when a completed byte is dropped on a full FIFO
- Frame_Err  output  1  one-cycle pulse when CS deasserts with 1–7 bits pending

## Operation
- Input conditioning: all 4 lines pass through 2 flops (s1, s2), then a third register (s3) holds the previous sample. SCLK rise = s2 & ~s3. CS fall and CS rise are detected the same way.
- Capture: while synchronized CS=0, each SCLK rise shifts DO into the shift register LSB-side (MSB first on the wire) and increments the 3-bit bit counter.
- A0 is taken from the synchronized sample at the SCLK rise of the 8th bit.
- On the 8th rise: {A0, byte} goes to the FIFO write stage, the bit counter wraps to 0, and Byte_Cnt increments (saturating).
- SCLK edges while CS=1 are ignored. The shift register and bit counter are held at 0.
- CS falling edge clears Byte_Cnt and the bit counter.
- CS rising edge with bit counter ≠ 0 discards the partial word and pulses Frame_Err for 1 cycle. Byte_Cnt then holds its value until the next CS fall.
- SCLK rise in the same cycle as a CS rise detection: the edge is ignored, because CS wins.
- FIFO:
  - Show-ahead: Rx_Data always shows the oldest entry.
  - Pop when Rd_En & Rx_Valid. Rd_En while empty has no effect.
  - Full, with a write and no pop in the same cycle: the write is dropped and Overflow is set.
  - Full, with a write and a pop in the same cycle: both are performed and the occupancy is unchanged.
  - Empty, with a write and Rd_En in the same cycle: only the write happens, because the pop is gated by the pre-write Rx_Valid=0.
- Overflow clears only on RST.
- RST, including mid-frame: clears the synchronizers to idle (CS=1, SCLK=1, others 0), the shift register, the bit counter and the FIFO pointers. The next captured byte needs a fresh CS fall.

## Timing
- Reset values: Rx_Data=9'h000, Rx_Valid=0, Byte_Cnt=0, Overflow=0, Frame_Err=0.
- Input constraints: SCLK high and low phases each ≥ 3 CLK periods. DO and A0 stable ≥ 3 CLK before and after the sampling SCLK rise. CS setup to the first SCLK rise ≥ 3 CLK.
- Cycle T is the CLK edge at which s1 first captures the 8th SCLK=1:
  - s2 is 1 at T+1.
  - The rise is detected and the shift register is updated at T+2.
  - The FIFO write happens at T+3.
  - Rx_Valid=1 and Byte_Cnt updated are visible after T+3, so the latency is 3 CLK from the first sample.
- Frame_Err asserts 3 CLK after CS=1 is first sampled and lasts exactly 1 cycle.
- Pop: Rx_Data and Rx_Valid show the next entry in the cycle after the Rd_En edge.
- Throughput: 1 byte per 8 SCLK periods. A FIFO read of 1 per cycle always keeps up.

## Test plan
- Reset idle: hold RST 3 cycles with SPI_In=4'b1010 → all outputs 0. Then 20 cycles with no activity → Rx_Valid stays 0.
- Single command byte: CS low, A0=0, send 8'hAF at SCLK period 8 CLK, CS high → Rx_Data=9'h0AF and Rx_Valid=1 three cycles after the 8th rise is sampled, Byte_Cnt=1. Then Rd_En=1 for 1 cycle → Rx_Valid=0.
- Mixed frame: one CS frame carrying A0=0 8'h40, then A0=1 bytes 8'h00, 8'hFF, 8'h5A → FIFO pops in order 9'h040, 9'h100, 9'h1FF, 9'h15A; Byte_Cnt=4; Frame_Err never set.
- Truncated frame: 5 bits (10110) then CS high → Frame_Err is a 1-cycle pulse and no FIFO write. Next frame sending 8'h3C → 9'h03C, with no leftover bits from the truncated frame.
- Overflow: 5 bytes 8'h01..8'h05 with Rd_En=0 → 4 entries 8'h01..8'h04 held, Overflow=1, Byte_Cnt=5. Repeat with a pop in the cycle of the 5th write → Overflow stays 0 and 8'h05 is retained.
- Reset mid-byte: RST pulsed after 4 bits → everything is cleared. SCLK edges before the next CS fall are ignored. The next full frame with 8'hC3 decodes correctly.
